// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address + R/W, one data byte, STOP.
// Open-drain SDA/SCL controls, quarter-period timing, SCL stretching.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] slave_addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  input  logic       sda_i,
  input  logic       scl_i,
  output logic       sda_o,
  output logic       scl_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ACK_A,
    S_DATA,
    S_ACK_D,
    S_STOP,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0] cnt;
  logic [1:0]    phase;
  logic [2:0]    bit_idx;
  logic          rw_q;
  logic [6:0]    addr_q;
  logic [7:0]    wdata_q;
  logic [7:0]    rx_q;
  logic [7:0]    abyte;

  logic accept;
  logic stall;
  logic last_cyc;
  logic slot_end;
  logic sample;

  assign accept   = (state == S_IDLE) && start;
  assign stall    = (phase == 2'd2) && !scl_i;
  assign last_cyc = (cnt == CNT_MAX) && !stall;
  assign slot_end = last_cyc && (phase == 2'd3);
  assign sample   = last_cyc && (phase == 2'd2);
  assign abyte    = {addr_q, rw_q};

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state: one step per completed bit slot
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nx = S_START;
      end
      S_START: begin
        if (slot_end) state_nx = S_ADDR;
      end
      S_ADDR: begin
        if (slot_end && bit_idx == 3'd7) state_nx = S_ACK_A;
      end
      S_ACK_A: begin
        if (slot_end) state_nx = ack_err ? S_STOP : S_DATA;
      end
      S_DATA: begin
        if (slot_end && bit_idx == 3'd7) state_nx = S_ACK_D;
      end
      S_ACK_D: begin
        if (slot_end) state_nx = S_STOP;
      end
      S_STOP: begin
        if (slot_end) state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Slot timing: cycle count, quarter phase, bit index; frozen while SCL is held low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      phase   <= 2'd0;
      bit_idx <= 3'd0;
    end else if (state == S_IDLE || state == S_DONE) begin
      cnt     <= '0;
      phase   <= 2'd0;
      bit_idx <= 3'd0;
    end else if (!stall) begin
      if (cnt == CNT_MAX) begin
        cnt   <= '0;
        phase <= phase + 2'd1;
        if (phase == 2'd3 && (state == S_ADDR || state == S_DATA)) begin
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Request latch, acknowledge status, receive shifter and read result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q    <= 1'b0;
      addr_q  <= 7'h00;
      wdata_q <= 8'h00;
      rx_q    <= 8'h00;
      rdata   <= 8'h00;
      ack_err <= 1'b0;
    end else begin
      if (accept) begin
        rw_q    <= rw;
        addr_q  <= slave_addr;
        wdata_q <= wdata;
        ack_err <= 1'b0;
      end
      if (sample && sda_i) begin
        if (state == S_ACK_A || (state == S_ACK_D && !rw_q)) begin
          ack_err <= 1'b1;
        end
      end
      if (sample && state == S_DATA && rw_q) begin
        rx_q <= {rx_q[6:0], sda_i};
      end
      if (slot_end && state == S_STOP && rw_q && !ack_err) begin
        rdata <= rx_q;
      end
    end
  end

  // Bus drive and status outputs decoded from state and phase
  always_comb begin
    sda_o = 1'b1;
    scl_o = 1'b1;
    busy  = 1'b1;
    done  = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_START: begin
        sda_o = !phase[1];
      end
      S_ADDR: begin
        scl_o = phase[1];
        sda_o = abyte[~bit_idx];
      end
      S_ACK_A: begin
        scl_o = phase[1];
      end
      S_DATA: begin
        scl_o = phase[1];
        sda_o = rw_q ? 1'b1 : wdata_q[~bit_idx];
      end
      S_ACK_D: begin
        scl_o = phase[1];
      end
      S_STOP: begin
        scl_o = phase[1];
        sda_o = (phase == 2'd3);
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: bus-level I2C slave with pull-ups,
// expected results queued per request and checked on each done pulse.
module tb_i2c_master_ctrl;

  localparam int D     = 4;
  localparam int FULL  = 80 * D + 1;
  localparam int SHORT = 44 * D + 1;
  localparam int TMO   = 3000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] slave_addr = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       sda_o;
  logic       scl_o;
  logic       sda_i;
  logic       scl_i;
  logic       slave_sda = 1'b1;
  logic       slave_scl = 1'b1;

  assign sda_i = sda_o & slave_sda;
  assign scl_i = scl_o & slave_scl;

  i2c_master_ctrl #(.CLK_DIV(D)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .rw(rw),
    .slave_addr(slave_addr),
    .wdata(wdata),
    .rdata(rdata),
    .busy(busy),
    .done(done),
    .ack_err(ack_err),
    .sda_i(sda_i),
    .scl_i(scl_i),
    .sda_o(sda_o),
    .scl_o(scl_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave knobs set per transaction
  logic [6:0] k_addr = 7'h00;
  logic [7:0] k_rbyte = 8'h00;
  bit         k_stretch = 0;
  bit         k_nackd = 0;

  // Slave observations
  int         bitn = 0;
  int         byten = 0;
  logic [7:0] shreg = 8'h00;
  logic [7:0] got_addr = 8'h00;
  logic [7:0] got_data = 8'h00;
  bit         matched = 0;
  bit         reading = 0;
  bit         mack = 0;
  bit         stop_flag = 0;
  bit         prev_sda = 1;
  bit         prev_scl = 1;
  int         stretch_left = 0;

  // Behavioural slave: reacts to bus edges seen at each falling clk edge
  always @(negedge clk) begin : slave
    bit cs;
    bit cl;
    cs = sda_i;
    cl = scl_i;
    if (reset) begin
      slave_sda = 1; slave_scl = 1; stretch_left = 0;
      prev_sda = 1; prev_scl = 1; bitn = 0; byten = 0;
    end else if (stretch_left > 0) begin
      stretch_left--;
      if (stretch_left == 0) slave_scl = 1;
    end else begin
      if (prev_scl && cl && prev_sda && !cs) begin
        bitn = 0; byten = 0; shreg = 0; matched = 0;
        reading = 0; stop_flag = 0; slave_sda = 1;
      end else if (prev_scl && cl && !prev_sda && cs) begin
        stop_flag = 1;
      end else if (!prev_scl && cl) begin
        if (bitn < 8) shreg = {shreg[6:0], cs};
        else if (bitn == 8 && byten == 1 && reading) mack = cs;
        if (k_stretch && byten == 0 && bitn == 3) begin
          slave_scl = 0;
          stretch_left = 20;
        end
        bitn++;
      end else if (prev_scl && !cl) begin
        if (bitn == 9) begin
          bitn = 0;
          byten++;
        end
        slave_sda = 1;
        if (bitn == 8) begin
          if (byten == 0) begin
            got_addr = shreg;
            matched = (shreg[7:1] == k_addr);
            reading = shreg[0];
            if (matched) slave_sda = 0;
          end else if (byten == 1 && !reading) begin
            got_data = shreg;
            if (!k_nackd) slave_sda = 0;
          end
        end else if (byten == 1 && reading && matched && bitn < 8) begin
          slave_sda = k_rbyte[7 - bitn];
        end
      end
      prev_sda = cs;
      prev_scl = cl;
    end
  end

  typedef struct {
    logic [7:0] abyte;
    bit         match;
    bit         rd;
    logic [7:0] wd;
    logic [7:0] rdat;
    bit         err;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  logic [7:0] m_rdata = 8'h00;

  // Reference model: outcome of one transaction from the protocol rules
  function automatic exp_t predict(input bit r, input logic [6:0] a,
                                   input logic [7:0] w, input logic [6:0] slv,
                                   input logic [7:0] rb, input bit st,
                                   input bit nk, input int acc);
    exp_t e;
    e.abyte = {a, r};
    e.match = (a == slv);
    e.rd    = r;
    e.wd    = w;
    e.err   = !e.match || (!r && nk);
    e.lat   = (e.match ? FULL : SHORT) + (st ? 20 : 0);
    if (e.match && r) m_rdata = rb;
    e.rdat  = m_rdata;
    e.acc   = acc;
    return e;
  endfunction

  // Monitor: compare each completion against the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        check("latency", cyc - e.acc + 1, e.lat);
        check("ack_err", ack_err, e.err);
        check("rdata", rdata, e.rdat);
        check("busy_at_done", busy, 0);
        check("addr_byte", got_addr, e.abyte);
        check("stop_seen", stop_flag, 1);
        stop_flag = 0;
        if (e.match && !e.rd) check("write_byte", got_data, e.wd);
        if (e.match && e.rd) check("master_nack", mack, 1);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      miscompares++;
      $display("FAIL idle_timeout: got busy=%0b expected 0", busy);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < TMO);
    if (!done) begin
      miscompares++;
      $display("FAIL done_timeout: got done=0 expected 1 within %0d cycles", TMO);
    end
  endtask

  task automatic run_txn(input bit r, input logic [6:0] a, input logic [7:0] w,
                         input logic [6:0] slv, input logic [7:0] rb,
                         input bit st, input bit nk);
    exp_t e;
    wait_idle();
    k_addr = slv; k_rbyte = rb; k_stretch = st; k_nackd = nk;
    rw = r; slave_addr = a; wdata = w; start = 1;
    e = predict(r, a, w, slv, rb, st, nk, cyc + 1);
    sb.push_back(e);
    @(negedge clk);
    start = 0;
    check("busy_rise", busy, 1);
    rw = 1'($urandom);
    slave_addr = 7'($urandom);
    wdata = 8'($urandom);
    repeat ($urandom_range(5, 60)) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done();
  endtask

  task automatic run_held(input int n);
    exp_t e;
    bit r;
    logic [6:0] a;
    logic [7:0] w;
    logic [7:0] rb;
    wait_idle();
    for (int i = 0; i < n; i++) begin
      r = 1'($urandom); a = 7'($urandom);
      w = 8'($urandom); rb = 8'($urandom);
      k_addr = a; k_rbyte = rb; k_stretch = 0; k_nackd = 0;
      rw = r; slave_addr = a; wdata = w; start = 1;
      e = predict(r, a, w, a, rb, 0, 0, (i == 0) ? cyc + 1 : cyc + 2);
      sb.push_back(e);
      if (i > 0) begin
        @(negedge clk);
        check("idle_gap", {busy, done}, 0);
      end
      @(negedge clk);
      check("busy_rise", busy, 1);
      wait_done();
    end
    start = 0;
  endtask

  task automatic run_reset_mid();
    bit idle_ok;
    wait_idle();
    k_addr = 7'h2A; k_stretch = 0; k_nackd = 0;
    rw = 0; slave_addr = 7'h2A; wdata = 8'h3C; start = 1;
    @(negedge clk);
    start = 0;
    repeat (14 * 4 * D + 2) @(negedge clk);
    check("pre_reset_scl", scl_o, 0);
    check("pre_reset_busy", busy, 1);
    reset = 1;
    #1;
    check("rst_sda", sda_o, 1);
    check("rst_scl", scl_o, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_rdata", rdata, 8'h00);
    m_rdata = 8'h00;
    repeat (3) @(negedge clk);
    reset = 0;
    idle_ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (busy || done || !sda_o || !scl_o) idle_ok = 0;
    end
    check("idle_after_reset", idle_ok, 1);
  endtask

  initial begin
    bit r;
    logic [6:0] a;
    logic [6:0] slv;
    reset = 1;
    repeat (3) @(negedge clk);
    check("reset_rdata", rdata, 8'h00);
    check("reset_busy", busy, 0);
    reset = 0;
    @(negedge clk);
    check("idle_sda", sda_o, 1);
    check("idle_scl", scl_o, 1);
    check("idle_done", done, 0);
    check("idle_ack_err", ack_err, 0);

    run_txn(0, 7'h50, 8'hA5, 7'h50, 8'h00, 0, 0);
    run_txn(1, 7'h3C, 8'h00, 7'h3C, 8'h96, 0, 0);
    run_txn(0, 7'h21, 8'h5A, 7'h50, 8'h00, 0, 0);
    run_txn(0, 7'h50, 8'hA5, 7'h50, 8'h00, 1, 0);
    run_reset_mid();
    run_txn(0, 7'h2A, 8'h3C, 7'h2A, 8'h00, 0, 0);
    run_txn(1, 7'h3C, 8'h00, 7'h3C, 8'h69, 0, 0);

    for (int i = 0; i < 10; i++) begin
      r = 1'($urandom);
      a = 7'($urandom);
      slv = ($urandom_range(0, 3) == 0) ? (a ^ 7'($urandom_range(1, 127))) : a;
      run_txn(r, a, 8'($urandom), slv, 8'($urandom),
              $urandom_range(0, 3) == 0, !r && ($urandom_range(0, 3) == 0));
    end

    run_held(3);
    wait_idle();
    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
